// File: rtl/dct_2d_stream.sv
// dct_2d_stream: streaming NxN 2D DCT using N shared MAC lanes and an in-place transpose buffer.
// Define DCT2D_STREAM_SAT_EN to saturate the writeback value; by default it wraps to DATA_WIDTH.
module dct_2d_stream #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N*N*COEFF_WIDTH-1:0]    coeff_matrix,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*DATA_WIDTH-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N*DATA_WIDTH-1:0]       out_data,
    output logic                          out_last,
    output logic                          busy
);
    localparam int PW   = DATA_WIDTH + COEFF_WIDTH;
    localparam int LOGN = $clog2(N);
    localparam int AW   = PW + LOGN;
    localparam int RW   = AW + 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);
`ifdef DCT2D_STREAM_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IN, S_RMAC, S_CMAC, S_OUT} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [LOGN-1:0]               r_r;
    logic [LOGN-1:0]               r_c;
    logic [LOGN-1:0]               r_k;
    logic [LOGN-1:0]               r_o;
    logic signed [DATA_WIDTH-1:0]  r_x    [N];
    logic signed [DATA_WIDTH-1:0]  r_tbuf [N][N];
    logic signed [AW-1:0]          r_acc  [N];

    logic signed [COEFF_WIDTH-1:0] w_coeff [N][N];
    logic signed [DATA_WIDTH-1:0]  w_op;
    logic signed [PW-1:0]          w_prod  [N];
    logic signed [AW-1:0]          w_sum   [N];
    logic signed [DATA_WIDTH-1:0]  w_wb    [N];
    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          w_k_last;
    logic                          w_r_last;
    logic                          w_c_last;
    logic                          w_o_last;

    // Round half up with an arithmetic shift, then reduce to DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] f_writeback(input logic signed [AW-1:0] i_acc);
        logic signed [RW-1:0]         v_ext;
        logic signed [RW-1:0]         v_rnd;
        logic signed [DATA_WIDTH-1:0] v_res;
        v_ext = RW'(i_acc);
        v_rnd = (v_ext + HALF) >>> FRAC_BITS;
`ifdef DCT2D_STREAM_SAT_EN
        if (v_rnd > RW'(D_MAX)) begin
            v_res = D_MAX;
        end else if (v_rnd < RW'(D_MIN)) begin
            v_res = D_MIN;
        end else begin
            v_res = v_rnd[DATA_WIDTH-1:0];
        end
`else
        v_res = v_rnd[DATA_WIDTH-1:0];
`endif
        return v_res;
    endfunction

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_k_last   = (r_k == LOGN'(N - 1));
    assign w_r_last   = (r_r == LOGN'(N - 1));
    assign w_c_last   = (r_c == LOGN'(N - 1));
    assign w_o_last   = (r_o == LOGN'(N - 1));

    always_comb begin
        for (int u = 0; u < N; u++) begin
            for (int k = 0; k < N; k++) begin
                w_coeff[u][k] = coeff_matrix[(u*N + k)*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
    end

    // The last product is folded into the writeback sum combinationally.
    always_comb begin
        w_op = (r_state == S_RMAC) ? r_x[r_k] : r_tbuf[r_k][r_c];
        for (int u = 0; u < N; u++) begin
            w_prod[u] = w_op * w_coeff[u][r_k];
            w_sum[u]  = r_acc[u] + AW'(w_prod[u]);
            w_wb[u]   = f_writeback(w_sum[u]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IN;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IN:    if (w_in_fire) w_next = S_RMAC;
            S_RMAC:  if (w_k_last) w_next = w_r_last ? S_CMAC : S_IN;
            S_CMAC:  if (w_k_last && w_c_last) w_next = S_OUT;
            S_OUT:   if (w_out_fire && w_o_last) w_next = S_IN;
            default: w_next = S_IN;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IN) && !reset;
        out_valid = (r_state == S_OUT) && !reset;
        out_last  = out_valid && w_o_last;
        busy      = !((r_state == S_IN) && (r_r == '0));
        out_data  = '0;
        if (out_valid) begin
            for (int v = 0; v < N; v++) begin
                out_data[v*DATA_WIDTH +: DATA_WIDTH] = r_tbuf[r_o][v];
            end
        end
    end

    // NOTE: the transpose buffer is reset explicitly because an aborted block must leave no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r <= '0;
            r_c <= '0;
            r_k <= '0;
            r_o <= '0;
            for (int u = 0; u < N; u++) begin
                r_x[u]   <= '0;
                r_acc[u] <= '0;
                for (int v = 0; v < N; v++) begin
                    r_tbuf[u][v] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IN: begin
                    if (w_in_fire) begin
                        r_k <= '0;
                        for (int u = 0; u < N; u++) begin
                            r_x[u]   <= in_data[u*DATA_WIDTH +: DATA_WIDTH];
                            r_acc[u] <= '0;
                        end
                    end
                end
                S_RMAC: begin
                    if (w_k_last) begin
                        r_k <= '0;
                        for (int u = 0; u < N; u++) begin
                            r_tbuf[r_r][u] <= w_wb[u];
                            r_acc[u]       <= '0;
                        end
                        if (w_r_last) begin
                            r_r <= '0;
                            r_c <= '0;
                        end else begin
                            r_r <= r_r + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                        for (int u = 0; u < N; u++) begin
                            r_acc[u] <= w_sum[u];
                        end
                    end
                end
                S_CMAC: begin
                    // Column c is only read by its own pass, so writing it back in place is safe.
                    if (w_k_last) begin
                        r_k <= '0;
                        for (int u = 0; u < N; u++) begin
                            r_tbuf[u][r_c] <= w_wb[u];
                            r_acc[u]       <= '0;
                        end
                        if (w_c_last) begin
                            r_c <= '0;
                            r_o <= '0;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                        for (int u = 0; u < N; u++) begin
                            r_acc[u] <= w_sum[u];
                        end
                    end
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        r_o <= w_o_last ? '0 : r_o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_2d_stream.sv
// tb_dct_2d_stream: randomized scoreboard bench for dct_2d_stream against a matrix-level reference model.
// Define DCT2D_STREAM_SAT_EN for both RTL and bench to check the saturating build.
module tb_dct_2d_stream;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FB = 14;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N*N*CW-1:0]   coeff_matrix = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N*DW-1:0]     in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [N*DW-1:0]     out_data;
    logic                out_last;
    logic                busy;

    dct_2d_stream #(
        .N(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAC_BITS(FB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coeff_matrix(coeff_matrix),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy)
    );

    typedef struct packed {
        logic [N*DW-1:0] data;
        logic            last;
    } exp_row_t;

    exp_row_t        exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    int              rdy_mode = 0;
    int              ov_rise = -1;
    int              acc_cyc [N];
    longint          cm [N][N];
    longint          xm [N][N];

    logic            m_held = 1'b0;
    logic            m_prev_ov = 1'b0;
    logic            m_after_last = 1'b0;
    logic [N*DW-1:0] m_held_data = '0;
    logic            m_held_last = 1'b0;
    int              m_row = 0;
    exp_row_t        m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference writeback: round half up, arithmetic shift, then clamp or wrap.
    function automatic longint wb(input longint acc);
        longint v;
        v = (acc + (longint'(1) <<< (FB - 1))) >>> FB;
`ifdef DCT2D_STREAM_SAT_EN
        if (v > (longint'(1) <<< (DW - 1)) - 1) v = (longint'(1) <<< (DW - 1)) - 1;
        if (v < -(longint'(1) <<< (DW - 1)))    v = -(longint'(1) <<< (DW - 1));
`else
        v = v & ((longint'(1) <<< DW) - 1);
        if (v >= (longint'(1) <<< (DW - 1))) v = v - (longint'(1) <<< DW);
`endif
        return v;
    endfunction

    // Y = C * X * C^T with a writeback after each 1D pass.
    task automatic push_expected();
        longint   z [N][N];
        longint   y [N][N];
        longint   s;
        exp_row_t e;
        for (int r = 0; r < N; r++) begin
            for (int u = 0; u < N; u++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += xm[r][k] * cm[u][k];
                z[r][u] = wb(s);
            end
        end
        for (int c = 0; c < N; c++) begin
            for (int u = 0; u < N; u++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += z[k][c] * cm[u][k];
                y[u][c] = wb(s);
            end
        end
        for (int u = 0; u < N; u++) begin
            e.data = '0;
            for (int v = 0; v < N; v++) e.data[v*DW +: DW] = DW'(y[u][v]);
            e.last = (u == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_identity(input longint scale);
        for (int u = 0; u < N; u++)
            for (int k = 0; k < N; k++) cm[u][k] = (u == k) ? scale : 0;
    endtask

    task automatic set_dct();
        real a;
        real v;
        for (int u = 0; u < N; u++) begin
            a = (u == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
            for (int k = 0; k < N; k++) begin
                v = a * $cos((2 * k + 1) * u * 3.14159265358979 / (2.0 * N)) * 16384.0;
                cm[u][k] = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
            end
        end
    endtask

    task automatic load_coeff();
        for (int u = 0; u < N; u++)
            for (int k = 0; k < N; k++) coeff_matrix[(u*N + k)*CW +: CW] = CW'(cm[u][k]);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                xm[r][k] = longint'(lo) + longint'($urandom_range(0, hi - lo));
    endtask

    task automatic fill_const(input int val);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) xm[r][k] = val;
    endtask

    task automatic fill_big();
        longint m;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                m = longint'($urandom_range(15000, 32767));
                xm[r][k] = ($urandom_range(0, 1) == 1) ? m : -m;
            end
    endtask

    function automatic logic [N*DW-1:0] pack_row(input int r);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(xm[r][k]);
        return d;
    endfunction

    // Every driver task starts and ends one time unit after a rising edge.
    task automatic send_row(input int r, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = pack_row(r);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                check_fail($sformatf("in_ready timeout on row %0d", r));
                break;
            end
        end
        acc_cyc[r] = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int gap_max, input int nrows, input bit push);
        for (int r = 0; r < nrows; r++)
            send_row(r, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        if (push) push_expected();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_fail($sformatf("%s: %0d rows never produced", name, exp_q.size()));
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("in_ready during reset", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", longint'(in_ready), 1);
        check("out_valid after reset", longint'(out_valid), 0);
        check("out_last after reset", longint'(out_last), 0);
        check("out_data after reset nonzero", longint'(out_data != '0), 0);
        check("busy after reset", longint'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                m_held = 1'b0;
                m_prev_ov = 1'b0;
                m_after_last = 1'b0;
                m_row = 0;
                continue;
            end
            if (m_after_last) begin
                check("busy after last row", longint'(busy), 0);
                check("in_ready after last row", longint'(in_ready), 1);
                m_after_last = 1'b0;
            end
            if (!out_valid) check("idle out_data nonzero", longint'(out_data != '0), 0);
            if (m_held) begin
                check("stall out_valid", longint'(out_valid), 1);
                check("stall out_data changed", longint'(out_data != m_held_data), 0);
                check("stall out_last", longint'(out_last), longint'(m_held_last));
            end
            if (out_valid && !m_prev_ov) ov_rise = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_fail("unexpected output row");
                end else begin
                    m_e = exp_q.pop_front();
                    for (int v = 0; v < N; v++)
                        check($sformatf("row%0d lane%0d", m_row, v),
                              longint'($signed(out_data[v*DW +: DW])),
                              longint'($signed(m_e.data[v*DW +: DW])));
                    check($sformatf("row%0d out_last", m_row), longint'(out_last), longint'(m_e.last));
                    check("busy during output", longint'(busy), 1);
                    m_row = m_e.last ? 0 : m_row + 1;
                    if (m_e.last) m_after_last = 1'b1;
                end
            end
            m_held      = out_valid && !out_ready;
            m_held_data = out_data;
            m_held_last = out_last;
            m_prev_ov   = out_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        do_reset(3);

        // Identity with in_valid held high: accept spacing and first-output latency.
        set_identity(16384);
        load_coeff();
        fill_rand(-2000, 2000);
        rdy_mode = 0;
        send_block(0, N, 1'b1);
        wait_drain("identity");
        for (int r = 1; r < N; r++)
            check($sformatf("accept spacing row%0d", r), longint'(acc_cyc[r] - acc_cyc[r-1]), N + 1);
        check("first out_valid latency", longint'(ov_rise - acc_cyc[0]), N * (N + 1) + N * N);

        // Identity with five stalled output cycles.
        fill_rand(-2000, 2000);
        rdy_mode = 2;
        send_block(0, N, 1'b1);
        n = 0;
        while (!out_valid && n < 500) begin @(negedge clk); n++; end
        if (!out_valid) check_fail("stall: out_valid never rose");
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_drain("stall");

        // Orthonormal DCT-II on a flat block, then random pixels with random backpressure.
        set_dct();
        load_coeff();
        fill_const(100);
        send_block(0, N, 1'b1);
        wait_drain("dct flat");
        fill_rand(-255, 255);
        rdy_mode = 1;
        send_block(3, N, 1'b1);
        wait_drain("dct random");

        // Large gain and large samples push both passes out of range.
        set_identity(30000);
        load_coeff();
        fill_big();
        rdy_mode = 0;
        send_block(0, N, 1'b1);
        wait_drain("overflow");

        // Abort a block after four rows, then run a fresh one.
        set_dct();
        load_coeff();
        fill_rand(-255, 255);
        send_block(0, 4, 1'b0);
        do_reset(2);
        fill_rand(-255, 255);
        send_block(2, N, 1'b1);
        wait_drain("after abort");

        // Two blocks back to back with random input gaps and random out_ready.
        rdy_mode = 1;
        fill_rand(-255, 255);
        send_block(4, N, 1'b1);
        fill_rand(-255, 255);
        send_block(4, N, 1'b1);
        wait_drain("back to back");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
